pulse_train_out: RTL
====================

Name: pulse_train_out

Overview:
Output-side counterpart of the trigger-capture path. It accepts a single-cycle trigger request in the `clock` domain and drives an external TTL line `q`. The line carries a programmable delay, then N pulses of programmable width and gap. Used to fire external instruments (AOM/shutter/camera triggers) from sequencer events, with busy/done/overrun status returned to the sequencer.

Parameters:
CNT_WIDTH, 16, width of delay/width/gap/count fields and internal counters
IDLE_LEVEL, 0, level of q when not pulsing (active level is ~IDLE_LEVEL)

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  gates acceptance of new triggers only
trigger  input  1  single-cycle start request, already synchronous to clock
abort  input  1  terminate any train in progress
delay  input  CNT_WIDTH  cycles from acceptance to first active edge
width  input  CNT_WIDTH  active cycles per pulse (0 treated as 1)
gap  input  CNT_WIDTH  idle cycles between pulses (0 treated as 1)
count  input  CNT_WIDTH  number of pulses (0 = no pulses)
q  output  1  registered external pulse line
busy  output  1  train in progress
done  output  1  one-cycle pulse on normal completion
overrun  output  1  one-cycle pulse when a trigger is rejected because busy
pulses_left  output  CNT_WIDTH  remaining pulses including the current one; 0 in IDLE

Behaviour:
- Reset (sync, active-high): state IDLE; q=IDLE_LEVEL; busy=0; done=0; overrun=0; pulses_left=0; all counters 0. Reset overrides everything, including a train mid-operation.
- States: IDLE, DELAY, ACTIVE, GAP. All outputs are registered.
- IDLE: if trigger&enable&!abort at cycle T:
  - latch delay, width, gap, count; busy=1 from T+1.
  - count=0: no state change past IDLE; busy stays 0, done=1 at T+1, q untouched.
  - delay=0: go to ACTIVE; q active from T+1.
  - otherwise go to DELAY; q active from T+1+delay.
- DELAY: count down latched delay; enter ACTIVE so that the first active cycle of q is T+1+delay.
- ACTIVE: q=~IDLE_LEVEL for max(width,1) cycles.
  - Last active cycle and pulses_left>1: decrement pulses_left, go to GAP.
  - Last active cycle and pulses_left==1: go to IDLE. In the next cycle q=IDLE_LEVEL, busy=0, done=1, pulses_left=0.
- GAP: q=IDLE_LEVEL for max(gap,1) cycles, then ACTIVE.
- Period of the train = max(width,1)+max(gap,1). Total active span = delay + N*width' + (N-1)*gap'.
- Input changes on delay/width/gap/count after acceptance have no effect on the running train.
- trigger while busy (any non-IDLE state): ignored. overrun=1 for exactly the next cycle. enable has no effect on this rejection.
- trigger while !enable in IDLE: ignored, no overrun.
- enable deasserted mid-train: train completes normally.
- abort in any state: the next cycle is IDLE with q=IDLE_LEVEL, busy=0, pulses_left=0; done is not asserted.
- abort and trigger in the same cycle: abort wins, trigger dropped, no overrun.
- Counters saturate-free: the internal down-counter reloads; max values (2^CNT_WIDTH-1) must work with no wrap to 0.
- done and overrun are never high two consecutive cycles from a single event.

Decomposition:
- Shared package: state encoding constants (IDLE, DELAY, ACTIVE, GAP) for reuse by the sequencer status readback.
- One natural sub-module: `load_down_counter` (load value, decrement, terminal-count flag, zero-as-one option). Instantiated once and reloaded per phase.

Test Plan:
1. reset, then trigger at T with delay=3, width=2, gap=4, count=3 -> q active cycles T+4..T+5, T+10..T+11, T+16..T+17; done at T+18; busy T+1..T+17.
2. delay=0, width=0, gap=0, count=2 -> q active at T+1 and T+3; done at T+4.
3. count=0 trigger -> q never changes, busy stays 0, done=1 at T+1.
4. Second trigger at T+5 during the train of test 1 -> overrun=1 at T+6 only; pulse timing unchanged.
5. abort at T+10 in test 1 -> q idle at T+11, busy=0, pulses_left=0, no done. Then enable=0 with trigger -> no response and no overrun.
6. reset asserted at T+5 mid-pulse -> all outputs at reset values at T+6. Then delay=16'hFFFF, width=1, count=1 -> q active exactly at T'+65536.

Source files
------------

// File: rtl/pulse_train_out_pkg.sv
// Shared definitions for the pulse train generator.
// The state encoding is exported so sequencer status readback can decode it.
package pulse_train_out_pkg;

    localparam int unsigned PtoStateWidth = 2;

    typedef enum logic [PtoStateWidth-1:0] {
        StIdle   = 2'd0,
        StDelay  = 2'd1,
        StActive = 2'd2,
        StGap    = 2'd3
    } pto_state_e;

endpackage

// File: rtl/load_down_counter.sv
// Loadable down-counter used to time each phase of the pulse train.
// tc is high during the final cycle of the loaded interval.
module load_down_counter #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 zero_as_one,
    input  logic [CNT_WIDTH-1:0] load_value,
    input  logic                 dec,
    output logic                 tc
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = (zero_as_one && (load_value == '0)) ? CNT_WIDTH'(1) : load_value;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q <= CNT_WIDTH'(1));

endmodule

// File: rtl/pulse_train_out.sv
// Triggered TTL pulse-train generator: programmable delay, then N pulses of
// programmable width and gap, with busy/done/overrun status.
module pulse_train_out #(
    parameter int unsigned CNT_WIDTH  = 16,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 trigger,
    input  logic                 abort,
    input  logic [CNT_WIDTH-1:0] delay,
    input  logic [CNT_WIDTH-1:0] width,
    input  logic [CNT_WIDTH-1:0] gap,
    input  logic [CNT_WIDTH-1:0] count,
    output logic                 q,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun,
    output logic [CNT_WIDTH-1:0] pulses_left
);

    import pulse_train_out_pkg::*;

    pto_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0] width_q, width_d;
    logic [CNT_WIDTH-1:0] gap_q, gap_d;
    logic [CNT_WIDTH-1:0] pulses_left_q, pulses_left_d;
    logic                 q_q, q_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 overrun_q, overrun_d;

    logic                 cnt_load;
    logic                 cnt_zero_as_one;
    logic [CNT_WIDTH-1:0] cnt_load_value;
    logic                 cnt_dec;
    logic                 cnt_tc;

    load_down_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_phase_cnt (
        .clock       (clock),
        .reset       (reset),
        .load        (cnt_load),
        .zero_as_one (cnt_zero_as_one),
        .load_value  (cnt_load_value),
        .dec         (cnt_dec),
        .tc          (cnt_tc)
    );

    always_comb begin
        state_d         = state_q;
        width_d         = width_q;
        gap_d           = gap_q;
        pulses_left_d   = pulses_left_q;
        done_d          = 1'b0;
        cnt_load        = 1'b0;
        cnt_zero_as_one = 1'b0;
        cnt_load_value  = '0;
        cnt_dec         = 1'b0;

        if (abort) begin
            state_d       = StIdle;
            pulses_left_d = '0;
            cnt_load      = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (trigger && enable) begin
                        width_d = width;
                        gap_d   = gap;
                        if (count == '0) begin
                            done_d = 1'b1;
                        end else begin
                            pulses_left_d = count;
                            cnt_load      = 1'b1;
                            if (delay == '0) begin
                                state_d         = StActive;
                                cnt_load_value  = width;
                                cnt_zero_as_one = 1'b1;
                            end else begin
                                state_d        = StDelay;
                                cnt_load_value = delay;
                            end
                        end
                    end
                end
                StDelay: begin
                    if (cnt_tc) begin
                        state_d         = StActive;
                        cnt_load        = 1'b1;
                        cnt_load_value  = width_q;
                        cnt_zero_as_one = 1'b1;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                StActive: begin
                    if (cnt_tc) begin
                        if (pulses_left_q != CNT_WIDTH'(1)) begin
                            state_d         = StGap;
                            pulses_left_d   = pulses_left_q - CNT_WIDTH'(1);
                            cnt_load        = 1'b1;
                            cnt_load_value  = gap_q;
                            cnt_zero_as_one = 1'b1;
                        end else begin
                            state_d       = StIdle;
                            pulses_left_d = '0;
                            done_d        = 1'b1;
                        end
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                StGap: begin
                    if (cnt_tc) begin
                        state_d         = StActive;
                        cnt_load        = 1'b1;
                        cnt_load_value  = width_q;
                        cnt_zero_as_one = 1'b1;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // Rejection is independent of enable; abort suppresses it.
        overrun_d = trigger && !abort && (state_q != StIdle);
        q_d       = (state_d == StActive) ? ~IDLE_LEVEL : IDLE_LEVEL;
        busy_d    = (state_d != StIdle);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            width_q       <= '0;
            gap_q         <= '0;
            pulses_left_q <= '0;
            q_q           <= IDLE_LEVEL;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            width_q       <= width_d;
            gap_q         <= gap_d;
            pulses_left_q <= pulses_left_d;
            q_q           <= q_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            overrun_q     <= overrun_d;
        end
    end

    assign q           = q_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign overrun     = overrun_q;
    assign pulses_left = pulses_left_q;

endmodule
